// File: rtl/dpu_pkg.sv
// Shared types and constants for the DPU convolution layer sequencer.
package dpu_pkg;

    localparam int MAX_MACS_DEF = 1152;
    localparam int DIM_W        = 9;
    localparam int CH_W         = 11;
    localparam int MACS_W       = 11;
    localparam int ACT_AW       = 24;
    localparam int W_AW         = 22;
    localparam int OUT_AW       = 24;
    localparam int BIAS_AW      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_RUN,
        ST_WRITE,
        ST_ADV,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [DIM_W-1:0] in_h;
        logic [DIM_W-1:0] in_w;
        logic [CH_W-1:0]  in_c;
        logic [CH_W-1:0]  out_c;
        logic             k3;
        logic             stride2;
        logic             pad;
    } cfg_t;

    // Wide enough for any 11-bit channel count times 9 so oversize requests are seen.
    function automatic logic [14:0] macs_needed(input logic [CH_W-1:0] in_c, input logic k3);
        return k3 ? (({4'd0, in_c} << 3) + {4'd0, in_c}) : {4'd0, in_c};
    endfunction

    // Caller guarantees in_d + 2*pad >= k, so the span never underflows.
    function automatic logic [DIM_W-1:0] out_dim(input logic [DIM_W-1:0] in_d, input logic k3,
                                                 input logic pad, input logic stride2);
        logic [DIM_W:0] span;
        span = {1'b0, in_d} + (pad ? (DIM_W+1)'(2) : (DIM_W+1)'(0)) - (k3 ? (DIM_W+1)'(3) : (DIM_W+1)'(1));
        return (stride2 ? span[DIM_W:1] : span[DIM_W-1:0]) + DIM_W'(1);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Kernel-walk counters plus activation/weight address generation for one output pixel.
// Addresses trail an eng_mac_index change by two cycles (act) / one cycle (weight); no backpressure.
module conv_addr_gen
    import dpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              run,
    input  logic [DIM_W-1:0]  in_h,
    input  logic [DIM_W-1:0]  in_w,
    input  logic [CH_W-1:0]   in_c,
    input  logic              k3,
    input  logic              stride2,
    input  logic              pad,
    input  logic [DIM_W-1:0]  oy,
    input  logic [DIM_W-1:0]  ox,
    input  logic [CH_W-1:0]   oc,
    input  logic [MACS_W-1:0] macs_count,
    input  logic [MACS_W-1:0] mac_index,
    output logic [ACT_AW-1:0] act_addr,
    output logic              act_zero,
    output logic [W_AW-1:0]   w_addr
);

    logic [1:0]        ky, kx, kmax;
    logic [CH_W-1:0]   ic;
    logic [MACS_W-1:0] prev_idx;
    logic [DIM_W:0]    iy_p, ix_p, iy, ix;
    logic              outside;
    logic [ACT_AW-1:0] act_lin;

    assign kmax = k3 ? 2'd2 : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ky       <= '0;
            kx       <= '0;
            ic       <= '0;
            prev_idx <= '0;
        end else if (clear) begin
            ky       <= '0;
            kx       <= '0;
            ic       <= '0;
            prev_idx <= '0;
        end else if (run) begin
            prev_idx <= mac_index;
            if (mac_index != prev_idx) begin
                if (ic == in_c - CH_W'(1)) begin
                    ic <= '0;
                    if (kx == kmax) begin
                        kx <= '0;
                        ky <= ky + 2'd1;
                    end else begin
                        kx <= kx + 2'd1;
                    end
                end else begin
                    ic <= ic + CH_W'(1);
                end
            end
        end
    end

    // Removing the pad from position zero wraps to a huge value, so one compare covers both edges.
    assign iy_p    = (stride2 ? {oy, 1'b0} : {1'b0, oy}) + {8'd0, ky};
    assign ix_p    = (stride2 ? {ox, 1'b0} : {1'b0, ox}) + {8'd0, kx};
    assign iy      = iy_p - {9'd0, pad};
    assign ix      = ix_p - {9'd0, pad};
    assign outside = (iy >= {1'b0, in_h}) || (ix >= {1'b0, in_w});
    assign act_lin = (ACT_AW'(iy) * ACT_AW'(in_w) + ACT_AW'(ix)) * ACT_AW'(in_c) + ACT_AW'(ic);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_addr <= '0;
            act_zero <= 1'b0;
            w_addr   <= '0;
        end else if (run) begin
            act_zero <= outside;
            act_addr <= outside ? '0 : act_lin;
            w_addr   <= W_AW'(oc) * W_AW'(macs_count) + W_AW'(mac_index);
        end
    end

endmodule

// File: rtl/conv_layer_seq.sv
// Layer sequencer: walks oy/ox/oc, launches the per-pixel engine and writes each int8 result.
// Four cycles of overhead per pixel plus engine time; start while busy is dropped.
module conv_layer_seq
    import dpu_pkg::*;
#(
    parameter int MAX_MACS = MAX_MACS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DIM_W-1:0]    cfg_in_h,
    input  logic [DIM_W-1:0]    cfg_in_w,
    input  logic [CH_W-1:0]     cfg_in_c,
    input  logic [CH_W-1:0]     cfg_out_c,
    input  logic                cfg_k3,
    input  logic                cfg_stride2,
    input  logic                cfg_pad,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic                eng_start,
    output logic [MACS_W-1:0]   eng_macs_count,
    input  logic [MACS_W-1:0]   eng_mac_index,
    input  logic                eng_done,
    input  logic signed [7:0]   eng_result,
    output logic [ACT_AW-1:0]   act_addr,
    output logic                act_zero,
    output logic [W_AW-1:0]     w_addr,
    output logic [BIAS_AW-1:0]  bias_addr,
    output logic                out_we,
    output logic [OUT_AW-1:0]   out_addr,
    output logic signed [7:0]   out_data
);

    seq_state_t         state, state_nxt;
    cfg_t               cfg_q;
    logic [DIM_W-1:0]   out_h, out_w, oy, ox, oh_calc, ow_calc;
    logic [CH_W-1:0]    oc;
    logic [MACS_W-1:0]  macs_q;
    logic signed [7:0]  result_q;
    logic [OUT_AW-1:0]  out_addr_q, pix_addr;
    logic               cfg_err_q;
    logic [14:0]        macs_req;
    logic [DIM_W:0]     h_span, w_span, k_span;
    logic               cfg_ok, accept, last_pixel;

    assign macs_req = macs_needed(cfg_in_c, cfg_k3);
    assign k_span   = cfg_k3 ? (DIM_W+1)'(3) : (DIM_W+1)'(1);
    assign h_span   = {1'b0, cfg_in_h} + (cfg_pad ? (DIM_W+1)'(2) : (DIM_W+1)'(0));
    assign w_span   = {1'b0, cfg_in_w} + (cfg_pad ? (DIM_W+1)'(2) : (DIM_W+1)'(0));
    // A kernel wider than the padded map would give an empty output plane; treat it as a zero dimension.
    assign cfg_ok   = (macs_req <= 15'(MAX_MACS)) && (cfg_in_h != '0) && (cfg_in_w != '0)
                   && (cfg_in_c != '0) && (cfg_out_c != '0) && !(cfg_pad && !cfg_k3)
                   && (h_span >= k_span) && (w_span >= k_span);
    assign accept   = (state == ST_IDLE) && start && cfg_ok;

    assign oh_calc    = out_dim(cfg_q.in_h, cfg_q.k3, cfg_q.pad, cfg_q.stride2);
    assign ow_calc    = out_dim(cfg_q.in_w, cfg_q.k3, cfg_q.pad, cfg_q.stride2);
    assign last_pixel = (oy == out_h - DIM_W'(1)) && (ox == out_w - DIM_W'(1))
                     && (oc == cfg_q.out_c - CH_W'(1));
    assign pix_addr   = (OUT_AW'(oy) * OUT_AW'(out_w) + OUT_AW'(ox)) * OUT_AW'(cfg_q.out_c) + OUT_AW'(oc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start && cfg_ok) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_RUN;
            ST_RUN:   if (eng_done) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_ADV;
            ST_ADV:   state_nxt = last_pixel ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        eng_start = (state == ST_ISSUE);
        out_we    = (state == ST_WRITE);
        done      = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q      <= '0;
            out_h      <= '0;
            out_w      <= '0;
            macs_q     <= '0;
            oy         <= '0;
            ox         <= '0;
            oc         <= '0;
            result_q   <= '0;
            out_addr_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= (state == ST_IDLE) && start && !cfg_ok;
            if (accept) begin
                cfg_q <= '{in_h: cfg_in_h, in_w: cfg_in_w, in_c: cfg_in_c, out_c: cfg_out_c,
                           k3: cfg_k3, stride2: cfg_stride2, pad: cfg_pad};
            end
            case (state)
                ST_LOAD: begin
                    out_h  <= oh_calc;
                    out_w  <= ow_calc;
                    macs_q <= cfg_q.k3 ? ((cfg_q.in_c << 3) + cfg_q.in_c) : cfg_q.in_c;
                    oy     <= '0;
                    ox     <= '0;
                    oc     <= '0;
                end
                ST_RUN: begin
                    if (eng_done) begin
                        result_q   <= eng_result;
                        out_addr_q <= pix_addr;
                    end
                end
                ST_ADV: begin
                    if (oc == cfg_q.out_c - CH_W'(1)) begin
                        oc <= '0;
                        if (ox == out_w - DIM_W'(1)) begin
                            ox <= '0;
                            oy <= (oy == out_h - DIM_W'(1)) ? '0 : oy + DIM_W'(1);
                        end else begin
                            ox <= ox + DIM_W'(1);
                        end
                    end else begin
                        oc <= oc + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_err        = cfg_err_q;
    assign eng_macs_count = macs_q;
    assign bias_addr      = oc[BIAS_AW-1:0];
    assign out_addr       = out_addr_q;
    assign out_data       = result_q;

    conv_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == ST_ISSUE),
        .run        (state == ST_RUN),
        .in_h       (cfg_q.in_h),
        .in_w       (cfg_q.in_w),
        .in_c       (cfg_q.in_c),
        .k3         (cfg_q.k3),
        .stride2    (cfg_q.stride2),
        .pad        (cfg_q.pad),
        .oy         (oy),
        .ox         (ox),
        .oc         (oc),
        .macs_count (macs_q),
        .mac_index  (eng_mac_index),
        .act_addr   (act_addr),
        .act_zero   (act_zero),
        .w_addr     (w_addr)
    );

endmodule

// File: tb/tb_conv_layer_seq.sv
// Randomised layer bench: a behavioural engine model plus a write monitor check every address.
module tb_conv_layer_seq;
    import dpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [8:0]         cfg_in_h, cfg_in_w;
    logic [10:0]        cfg_in_c, cfg_out_c;
    logic               cfg_k3, cfg_stride2, cfg_pad;
    logic               busy, done, cfg_err, eng_start;
    logic [10:0]        eng_macs_count;
    logic [10:0]        eng_mac_index;
    logic               eng_done;
    logic signed [7:0]  eng_result;
    logic [23:0]        act_addr;
    logic               act_zero;
    logic [21:0]        w_addr;
    logic [9:0]         bias_addr;
    logic               out_we;
    logic [23:0]        out_addr;
    logic signed [7:0]  out_data;

    always #5 clk = ~clk;

    conv_layer_seq #(.MAX_MACS(1152)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_in_c(cfg_in_c), .cfg_out_c(cfg_out_c),
        .cfg_k3(cfg_k3), .cfg_stride2(cfg_stride2), .cfg_pad(cfg_pad),
        .busy(busy), .done(done), .cfg_err(cfg_err), .eng_start(eng_start),
        .eng_macs_count(eng_macs_count), .eng_mac_index(eng_mac_index),
        .eng_done(eng_done), .eng_result(eng_result),
        .act_addr(act_addr), .act_zero(act_zero), .w_addr(w_addr), .bias_addr(bias_addr),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    int n_chk = 0, n_err = 0;
    int L_h, L_w, L_c, L_oc, L_k, L_s, L_p, L_oh, L_ow, L_macs;
    int pix, n_start, n_done, n_wr, n_cfgerr, zero_pix0, rst_epoch;
    logic signed [7:0] res_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Engine model: holds each MAC index a random while, checks addresses, then returns a result.
    task automatic run_pixel();
        int p, oy, ox, oc, ic, kx, ky, iy, ix, ep, exp_addr;
        bit exp_zero, aborted;
        p = pix; pix++; ep = rst_epoch; aborted = 0;
        oc = p % L_oc; ox = (p / L_oc) % L_ow; oy = p / (L_oc * L_ow);
        chk("bias_addr", bias_addr, oc);
        chk("macs_count", eng_macs_count, L_macs);
        for (int m = 0; m < L_macs; m++) begin
            eng_mac_index = 11'(m);
            repeat (2 + $urandom_range(0, 2)) @(posedge clk);
            #1;
            if (rst_n !== 1'b1 || ep != rst_epoch) begin aborted = 1; break; end
            ic = m % L_c; kx = (m / L_c) % L_k; ky = m / (L_c * L_k);
            iy = oy * L_s + ky - L_p; ix = ox * L_s + kx - L_p;
            exp_zero = (iy < 0) || (iy >= L_h) || (ix < 0) || (ix >= L_w);
            exp_addr = exp_zero ? 0 : (iy * L_w + ix) * L_c + ic;
            chk("act_zero", act_zero, exp_zero);
            chk("act_addr", act_addr, exp_addr);
            chk("w_addr", w_addr, oc * L_macs + m);
            if (p == 0 && exp_zero) zero_pix0++;
        end
        if (!aborted) begin
            eng_result = 8'($urandom);
            res_q.push_back(eng_result);
            eng_done = 1'b1;
            @(posedge clk); #1;
            eng_done = 1'b0;
        end
        eng_mac_index = '0;
    endtask

    initial begin : engine
        eng_mac_index = '0; eng_done = 1'b0; eng_result = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1 && eng_start === 1'b1) run_pixel();
        end
    end

    initial begin : monitor
        int wn;
        forever begin
            @(posedge clk); #1;
            if (rst_n === 1'b1) begin
                if (eng_start) n_start++;
                if (done) n_done++;
                if (cfg_err) n_cfgerr++;
                if (out_we) begin
                    wn = n_wr;
                    chk("out_addr", out_addr,
                        ((wn / (L_oc * L_ow)) * L_ow + (wn / L_oc) % L_ow) * L_oc + wn % L_oc);
                    if (res_q.size() == 0) chk("out_data_avail", 0, 1);
                    else chk("out_data", out_data, res_q.pop_front());
                    n_wr++;
                end
            end
        end
    end

    task automatic set_layer(input int h, input int w, input int c, input int oc,
                             input int k3, input int s2, input int pad);
        L_h = h; L_w = w; L_c = c; L_oc = oc; L_k = k3 ? 3 : 1; L_s = s2 ? 2 : 1; L_p = pad;
        L_oh = (h + 2 * pad - L_k) / L_s + 1;
        L_ow = (w + 2 * pad - L_k) / L_s + 1;
        L_macs = c * L_k * L_k;
        pix = 0; n_start = 0; n_done = 0; n_wr = 0; n_cfgerr = 0; zero_pix0 = 0;
        res_q.delete();
        cfg_in_h = 9'(h); cfg_in_w = 9'(w); cfg_in_c = 11'(c); cfg_out_c = 11'(oc);
        cfg_k3 = 1'(k3); cfg_stride2 = 1'(s2); cfg_pad = 1'(pad);
    endtask

    task automatic run_layer(input int h, input int w, input int c, input int oc,
                             input int k3, input int s2, input int pad, input bit poke);
        int cyc, npix;
        set_layer(h, w, c, oc, k3, s2, pad);
        npix = L_oh * L_ow * L_oc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        cyc = 0;
        while (n_done == 0 && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 25) begin
                start = 1'b1; cfg_in_c = 11'd129;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("layer_timeout", cyc < 30000, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("done_count", n_done, 1);
        chk("eng_start_count", n_start, npix);
        chk("write_count", n_wr, npix);
        chk("no_cfg_err", n_cfgerr, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic reject(input int h, input int w, input int c, input int oc,
                          input int k3, input int s2, input int pad);
        set_layer(h, w, c, oc, k3, s2, pad);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rej_cfg_err", cfg_err, 1);
        chk("rej_busy", busy, 0);
        @(posedge clk); #1;
        chk("rej_err_pulse", cfg_err, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("rej_busy_late", busy, 0);
        chk("rej_no_eng_start", n_start, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int h, w, c, oc, k3, s2, pad, lo;
        rst_n = 1'b0; start = 1'b0; rst_epoch = 0;
        set_layer(1, 1, 1, 1, 0, 0, 0);
        #1;
        chk("reset_outputs", |{busy, done, cfg_err, eng_start, eng_macs_count, act_addr, act_zero,
                               w_addr, bias_addr, out_we, out_addr, out_data}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_idle", {busy, out_we, eng_start}, 0);
        chk("post_reset_writes", n_wr, 0);

        run_layer(2, 2, 1, 1, 0, 0, 0, 0);
        run_layer(4, 4, 2, 1, 1, 0, 1, 1);
        chk("pad_zero_pix0", zero_pix0, 10);
        run_layer(5, 5, 1, 2, 1, 1, 0, 0);

        reject(4, 4, 129, 1, 1, 0, 0);
        reject(0, 4, 2, 1, 0, 0, 0);
        reject(4, 4, 2, 1, 0, 0, 1);

        // Largest accepted kernel volume, interrupted by reset mid-pixel.
        set_layer(3, 3, 128, 1, 1, 0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("big_busy", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("big_macs_count", eng_macs_count, 1152);
        repeat (40) @(posedge clk);
        #1;
        rst_epoch++;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", |{busy, done, cfg_err, eng_start, eng_macs_count, act_addr, act_zero,
                                      w_addr, bias_addr, out_we, out_addr, out_data}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("after_reset_no_write", n_wr, 0);
        chk("after_reset_idle", busy, 0);
        run_layer(3, 3, 2, 2, 1, 0, 1, 0);

        for (int r = 0; r < 4; r++) begin
            k3  = $urandom_range(0, 1);
            pad = k3 ? $urandom_range(0, 1) : 0;
            s2  = $urandom_range(0, 1);
            lo  = (k3 && !pad) ? 3 : 1;
            h   = $urandom_range(lo, 5);
            w   = $urandom_range(lo, 5);
            c   = $urandom_range(1, 3);
            oc  = $urandom_range(1, 2);
            run_layer(h, w, c, oc, k3, s2, pad, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
